// File: rtl/mem_access_unit.sv
// Memory-stage data-bus access unit: issues one LW/SW per instruction on the split
// address/data handshake, stalls the pipeline until it completes, and holds load data.
module mem_access_unit #(
  parameter int          CNT_W = 16,
  parameter logic [5:0]  LW_OP = 6'h23,
  parameter logic [5:0]  SW_OP = 6'h2b
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             M_valid,
  input  logic [5:0]       M_icode,
  input  logic [31:0]      M_addr,
  input  logic [31:0]      M_wdata,
  output logic             dreq_valid,
  output logic [31:0]      dreq_addr,
  output logic [3:0]       dreq_strobe,
  output logic [31:0]      dreq_wdata,
  input  logic             dresp_addr_ok,
  input  logic             dresp_data_ok,
  input  logic [31:0]      dresp_data,
  output logic [31:0]      m_data,
  output logic             mem_stall,
  output logic             m_addr_err,
  output logic [CNT_W-1:0] m_stall_cycles
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         strobe_q, strobe_d;
  logic               is_load_q, is_load_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic is_mem;
  logic aligned;

  assign is_mem  = M_valid && ((M_icode == LW_OP) || (M_icode == SW_OP));
  assign aligned = (M_addr[1:0] == 2'b00);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strobe_d   = strobe_q;
    is_load_d  = is_load_q;
    rdata_d    = rdata_q;
    mem_stall  = 1'b0;
    m_addr_err = 1'b0;
    dreq_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (is_mem) begin
          if (aligned) begin
            addr_d    = M_addr;
            wdata_d   = M_wdata;
            strobe_d  = (M_icode == SW_OP) ? 4'hF : 4'h0;
            is_load_d = (M_icode == LW_OP);
            mem_stall = 1'b1;
            state_d   = REQ;
          end else begin
            m_addr_err = 1'b1;
          end
        end
      end
      REQ: begin
        dreq_valid = 1'b1;
        mem_stall  = 1'b1;
        // data_ok is only meaningful once the address phase has been accepted
        if (dresp_addr_ok) begin
          if (dresp_data_ok) begin
            if (is_load_q) rdata_d = dresp_data;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        mem_stall = 1'b1;
        if (dresp_data_ok) begin
          if (is_load_q) rdata_d = dresp_data;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cnt_d = cnt_q;
    if (mem_stall && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      strobe_q  <= '0;
      is_load_q <= 1'b0;
      rdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strobe_q  <= strobe_d;
      is_load_q <= is_load_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign dreq_addr      = addr_q;
  assign dreq_strobe    = strobe_q;
  assign dreq_wdata     = wdata_q;
  assign m_data         = rdata_q;
  assign m_stall_cycles = cnt_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed plus random LW/SW transactions against a
// transaction-level model of stall length, bus fields, load data and counters.
module tb_mem_access_unit;

  localparam logic [5:0] LW = 6'h23;
  localparam logic [5:0] SW = 6'h2b;

  logic        clk = 1'b0;
  logic        reset;
  logic        M_valid;
  logic [5:0]  M_icode;
  logic [31:0] M_addr, M_wdata;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [31:0] dresp_data;

  logic        dreq_valid, mem_stall, m_addr_err;
  logic [31:0] dreq_addr, dreq_wdata, m_data;
  logic [3:0]  dreq_strobe;
  logic [15:0] m_stall_cycles;

  logic        dreq_valid4, mem_stall4, m_addr_err4;
  logic [31:0] dreq_addr4, dreq_wdata4, m_data4;
  logic [3:0]  dreq_strobe4;
  logic [3:0]  m_stall_cycles4;

  always #5 clk = ~clk;

  mem_access_unit #(.CNT_W(16), .LW_OP(LW), .SW_OP(SW)) u_dut (
    .clk(clk), .reset(reset),
    .M_valid(M_valid), .M_icode(M_icode), .M_addr(M_addr), .M_wdata(M_wdata),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_strobe(dreq_strobe),
    .dreq_wdata(dreq_wdata),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .m_data(m_data), .mem_stall(mem_stall), .m_addr_err(m_addr_err),
    .m_stall_cycles(m_stall_cycles)
  );

  mem_access_unit #(.CNT_W(4), .LW_OP(LW), .SW_OP(SW)) u_dut4 (
    .clk(clk), .reset(reset),
    .M_valid(M_valid), .M_icode(M_icode), .M_addr(M_addr), .M_wdata(M_wdata),
    .dreq_valid(dreq_valid4), .dreq_addr(dreq_addr4), .dreq_strobe(dreq_strobe4),
    .dreq_wdata(dreq_wdata4),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .m_data(m_data4), .mem_stall(mem_stall4), .m_addr_err(m_addr_err4),
    .m_stall_cycles(m_stall_cycles4)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] exp_mdata;
  int          exp_stalls;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int t, input int m);
    return (t > m) ? m : t;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_cnt16"}, {16'h0, m_stall_cycles}, sat(exp_stalls, 65535));
    check({tag, "_cnt4"}, {28'h0, m_stall_cycles4}, sat(exp_stalls, 15));
  endtask

  task automatic idle_bus();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = 32'h0;
  endtask

  // One instruction in M. a = REQ cycles before addr_ok (0 = first REQ cycle),
  // d = cycles from addr_ok to data_ok (0 = same cycle). Called #1 after a posedge.
  task automatic do_access(input logic v, input logic [5:0] ic, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int a, input int d);
    bit          is_mem, aligned, accepted, done;
    int          req_seen, stall_seen, wait_seen, cyc;
    logic [3:0]  exp_strobe;
    is_mem     = v && (ic == LW || ic == SW);
    aligned    = (addr[1:0] == 2'b00);
    exp_strobe = (ic == SW) ? 4'hF : 4'h0;
    accepted = 0; done = 0; req_seen = 0; stall_seen = 0; wait_seen = 0; cyc = 0;
    M_valid = v; M_icode = ic; M_addr = addr; M_wdata = wd;
    idle_bus();

    if (!(is_mem && aligned)) begin
      @(negedge clk);
      check("nomem_stall", {31'h0, mem_stall}, 32'h0);
      check("nomem_err", {31'h0, m_addr_err}, {31'h0, is_mem});
      check("nomem_dreq_valid", {31'h0, dreq_valid}, 32'h0);
      check("nomem_mdata", m_data, exp_mdata);
      @(posedge clk); #1;
      M_valid = 1'b0;
      check_counters("nomem");
      $display("txn v=%0b ic=%h addr=%h -> no access (err=%0b)", v, ic, addr, is_mem);
      return;
    end

    while (!done) begin
      @(negedge clk);
      idle_bus();
      dresp_data = $urandom;
      if (mem_stall) begin
        stall_seen++;
        check("hold_mdata", m_data, exp_mdata);
      end
      if (dreq_valid) begin
        check("req_addr", dreq_addr, addr);
        check("req_strobe", {28'h0, dreq_strobe}, {28'h0, exp_strobe});
        check("req_wdata", dreq_wdata, wd);
        if (req_seen == a) begin
          dresp_addr_ok = 1'b1;
          accepted = 1;
          if (d == 0) begin
            dresp_data_ok = 1'b1;
            dresp_data    = rd;
          end
        end else begin
          dresp_data_ok = 1'($urandom_range(0, 1));
        end
        req_seen++;
      end else if (accepted && mem_stall) begin
        wait_seen++;
        if (wait_seen == d) begin
          dresp_data_ok = 1'b1;
          dresp_data    = rd;
        end
      end else if (!mem_stall && stall_seen > 0) begin
        done = 1;
      end
      cyc++;
      if (!done && cyc > 64) begin
        check("timeout", 32'h1, 32'h0);
        break;
      end
    end

    if (ic == LW) exp_mdata = rd;
    exp_stalls += 2 + a + d;
    check("done_mdata", m_data, exp_mdata);
    check("stall_len", stall_seen, 2 + a + d);
    check("req_cycles", req_seen, a + 1);
    @(posedge clk); #1;
    M_valid = 1'b0;
    check_counters("post");
    $display("txn %s addr=%h a=%0d d=%0d stalls=%0d m_data=%h",
             (ic == LW) ? "LW" : "SW", addr, a, d, stall_seen, m_data);
  endtask

  task automatic reset_in_wait();
    M_valid = 1'b1; M_icode = LW; M_addr = 32'h0000_0100; M_wdata = 32'h0;
    idle_bus();
    @(negedge clk);                        // IDLE
    @(negedge clk);                        // REQ: accept address only
    check("rst_req_valid", {31'h0, dreq_valid}, 32'h1);
    dresp_addr_ok = 1'b1;
    @(negedge clk);                        // WAIT
    idle_bus();
    check("rst_wait_stall", {31'h0, mem_stall}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    M_valid = 1'b0;
    dresp_data_ok = 1'b1;
    dresp_data    = 32'hAAAA_AAAA;
    exp_mdata  = 32'h0;
    exp_stalls = 0;
    @(negedge clk);
    check("rst_dreq_valid", {31'h0, dreq_valid}, 32'h0);
    check("rst_stall", {31'h0, mem_stall}, 32'h0);
    @(posedge clk); #1;
    idle_bus();
    check("rst_late_mdata", m_data, 32'h0);
    check_counters("rst");
    $display("txn reset-in-WAIT then late data_ok -> m_data=%h", m_data);
  endtask

  initial begin
    reset = 1'b1;
    M_valid = 1'b0; M_icode = 6'h0; M_addr = 32'h0; M_wdata = 32'h0;
    idle_bus();
    exp_mdata  = 32'h0;
    exp_stalls = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_valid", {31'h0, dreq_valid}, 32'h0);
    check("rst_addr", dreq_addr, 32'h0);
    check("rst_strobe", {28'h0, dreq_strobe}, 32'h0);
    check("rst_wdata", dreq_wdata, 32'h0);
    check("rst_mdata", m_data, 32'h0);
    check("rst_stall0", {31'h0, mem_stall}, 32'h0);
    check("rst_err0", {31'h0, m_addr_err}, 32'h0);
    check_counters("rst0");
    @(posedge clk); #1;
    reset = 1'b0;

    do_access(1'b1, LW, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0);
    do_access(1'b1, SW, 32'h0000_0010, 32'h1234_5678, 32'h0BAD_F00D, 2, 2);
    do_access(1'b1, LW, 32'h0000_0006, 32'h0, 32'h0, 0, 0);
    do_access(1'b1, LW, 32'h0000_0000, 32'h0, 32'h0000_0011, 0, 0);
    do_access(1'b1, LW, 32'h0000_0004, 32'h0, 32'h0000_0022, 0, 0);
    do_access(1'b0, LW, 32'h0000_0008, 32'h0, 32'h0, 0, 0);
    do_access(1'b1, 6'h08, 32'h0000_0008, 32'h0, 32'h0, 0, 0);
    do_access(1'b1, SW, 32'h0000_0020, 32'hCAFE_0001, 32'h0, 15, 4);
    reset_in_wait();

    for (int i = 0; i < 150; i++) begin
      logic        v;
      logic [5:0]  ic;
      logic [31:0] addr;
      int          sel;
      v   = ($urandom_range(0, 9) != 0);
      sel = $urandom_range(0, 4);
      ic  = (sel < 2) ? LW : (sel < 4) ? SW : 6'($urandom);
      addr = $urandom;
      if ($urandom_range(0, 4) != 0) addr[1:0] = 2'b00;
      do_access(v, ic, addr, $urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
